div_issue_unit: RTL and testbench

//  EX-stage initiator for the multi-cycle divider. It accepts DIV/DIVU from EX and issues

---
 rtl/mycpu_div_pkg.sv | 20 ++
 rtl/div_issue_unit.sv | 86 ++++++++
 tb/tb_div_issue_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mycpu_div_pkg.sv
// Shared types and helpers for the divide issue path.
// Operand width is fixed at 32 because the results land in the MIPS HI/LO pair.
package mycpu_div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } div_state_t;

    // Two's-complement magnitude. 0x8000_0000 maps to itself, which the divider
    // reads correctly as an unsigned 2^31.
    function automatic logic [DIV_W-1:0] abs32(input logic [DIV_W-1:0] v,
                                               input logic             is_signed);
        return (is_signed && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_issue_unit.sv
// EX-stage initiator for the multi-cycle divider: registers magnitudes and sign
// fix-up flags, pulses div_begin, stalls EX until div_done, then writes HI/LO.
module div_issue_unit
    import mycpu_div_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_div_valid,
    input  logic              ex_div_signed,
    input  logic [DATA_W-1:0] ex_rs_data,
    input  logic [DATA_W-1:0] ex_rt_data,
    input  logic              flush,
    output logic              div_begin,
    output logic              div_sign,
    output logic              div_dividend_sign,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder,
    input  logic              div_done,
    output logic              div_stall,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_wdata,
    output logic [DATA_W-1:0] lo_wdata
);

    div_state_t state_q, state_nxt;
    logic       issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            div_begin         <= 1'b0;
            div_sign          <= 1'b0;
            div_dividend_sign <= 1'b0;
            div_dividend      <= '0;
            div_divisor       <= '0;
        end else begin
            state_q   <= state_nxt;
            div_begin <= issue;
            // Operands stay frozen through BUSY/DRAIN; the divider samples them
            // over many cycles, not only at div_begin.
            if (issue) begin
                div_dividend      <= abs32(ex_rs_data, ex_div_signed);
                div_divisor       <= abs32(ex_rt_data, ex_div_signed);
                div_sign          <= ex_div_signed & (ex_rs_data[DATA_W-1] ^ ex_rt_data[DATA_W-1]);
                div_dividend_sign <= ex_div_signed & ex_rs_data[DATA_W-1];
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        issue     = 1'b0;
        div_stall = 1'b0;
        hilo_we   = 1'b0;
        case (state_q)
            IDLE: begin
                issue     = ex_div_valid & ~flush;
                div_stall = issue;
                if (issue) state_nxt = BUSY;
            end
            BUSY: begin
                div_stall = ~div_done;
                if (div_done) begin
                    hilo_we   = ~flush;
                    state_nxt = IDLE;
                end else if (flush) begin
                    // Divider cannot be aborted; wait out its result and drop it.
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                div_stall = ex_div_valid;
                if (div_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hi_wdata = hilo_we ? div_remainder : '0;
    assign lo_wdata = hilo_we ? div_quotient  : '0;

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit with a behavioural divider partner and a
// scoreboard monitor checking every HI/LO write.
module tb_div_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div_valid = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_rs_data = '0;
    logic [31:0] ex_rt_data = '0;
    logic        flush = 1'b0;
    logic        div_begin, div_sign, div_dividend_sign;
    logic [31:0] div_dividend, div_divisor;
    logic [31:0] div_quotient, div_remainder;
    logic        div_done;
    logic        div_stall, hilo_we;
    logic [31:0] hi_wdata, lo_wdata;

    always #5 clk = ~clk;

    div_issue_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .flush(flush),
        .div_begin(div_begin), .div_sign(div_sign), .div_dividend_sign(div_dividend_sign),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
        .div_stall(div_stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Divider partner: begin seen at start of cycle 1, done during cycle 36.
    logic [31:0] m_q = '0, m_r = '0;
    logic        m_done = 1'b0, spur_done = 1'b0;
    bit          m_act = 1'b0;
    int          m_cnt = 0;

    initial forever begin
        @(posedge clk); #1;
        m_done = 1'b0;
        if (rst) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_cnt++;
            if (m_cnt == 36) begin
                m_done = 1'b1;
                m_act  = 1'b0;
            end
        end else if (div_begin) begin
            m_act = 1'b1;
            m_cnt = 1;
            m_q = (div_divisor == 0) ? 32'hffff_ffff : div_dividend / div_divisor;
            m_r = (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
            if (div_sign)          m_q = -m_q;
            if (div_dividend_sign) m_r = -m_r;
        end
    end

    assign div_done      = m_done | spur_done;
    assign div_quotient  = m_done ? m_q : 32'hdead_beef;
    assign div_remainder = m_done ? m_r : 32'hdead_beef;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && hilo_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_we: got hi=%h lo=%h want no write", hi_wdata, lo_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi_wdata", hi_wdata, e.hi);
                chk("lo_wdata", lo_wdata, e.lo);
            end
        end
    end

    task automatic next();
        @(posedge clk); #2;
    endtask

    // Cycles 0..36 of one divide; fl36 flushes the completion cycle.
    task automatic do_div(input bit sg, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic [31:0] dd, input logic [31:0] dv,
                          input bit s, input bit ds, input bit fl36);
        int errs;
        exp_t e;
        next();
        ex_div_valid = 1'b1; ex_div_signed = sg; ex_rs_data = rs; ex_rt_data = rt; flush = 1'b0;
        if (!fl36) begin
            e.hi = hi; e.lo = lo;
            sb.push_back(e);
        end
        #1;
        chk("stall_c0", div_stall, 1);
        chk("begin_c0", div_begin, 0);
        next();
        ex_div_valid = 1'b0;
        #1;
        chk("begin_c1", div_begin, 1);
        chk("stall_c1", div_stall, 1);
        chk("dividend", div_dividend, dd);
        chk("divisor", div_divisor, dv);
        chk("div_sign", div_sign, s);
        chk("div_dividend_sign", div_dividend_sign, ds);
        errs = 0;
        for (int c = 2; c <= 35; c++) begin
            next(); #1;
            if (div_begin !== 1'b0 || div_stall !== 1'b1 || hilo_we !== 1'b0) errs++;
        end
        chk("busy_hold", errs, 0);
        next();
        flush = fl36;
        #1;
        chk("stall_c36", div_stall, 0);
        chk("we_c36", hilo_we, !fl36);
    endtask

    initial begin
        int errs;
        // Reset state
        next(); next(); #1;
        chk("rst_begin", div_begin, 0);
        chk("rst_we", hilo_we, 0);
        chk("rst_stall", div_stall, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        chk("rst_signs", {div_sign, div_dividend_sign}, 0);
        chk("rst_hi", hi_wdata, 0);
        chk("rst_lo", lo_wdata, 0);
        rst = 1'b0;

        // DIVU 100/7
        do_div(0, 32'd100, 32'd7, 32'd2, 32'd14, 32'd100, 32'd7, 0, 0, 0);
        next(); #1;
        chk("we_c37", hilo_we, 0);
        chk("begin_c37", div_begin, 0);

        // DIV -7/2
        do_div(1, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 32'd7, 32'd2, 1, 1, 0);
        // DIV 0x8000_0000 / -1
        do_div(1, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'd1, 0, 1, 0);
        // DIVU by zero: pass-through of whatever the divider reports
        do_div(0, 32'd5, 32'd0, 32'd5, 32'hffff_ffff, 32'd5, 32'd0, 0, 0, 0);

        // Flush while issuing: nothing starts
        next();
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs_data = 32'd50; ex_rt_data = 32'd5; flush = 1'b1;
        #1;
        chk("flush_issue_stall", div_stall, 0);
        next();
        ex_div_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_issue_begin", div_begin, 0);

        // Spurious done while IDLE
        next();
        spur_done = 1'b1;
        #1;
        chk("spur_we", hilo_we, 0);
        chk("spur_stall", div_stall, 0);
        next();
        spur_done = 1'b0;

        // Flush in cycle 10 of BUSY; new DIVU from cycle 12 waits for IDLE
        next();
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs_data = 32'd100; ex_rt_data = 32'd7;
        next();
        ex_div_valid = 1'b0;
        for (int c = 2; c <= 10; c++) next();
        flush = 1'b1;
        #1;
        chk("flush_busy_stall", div_stall, 1);
        next();
        flush = 1'b0;
        #1;
        chk("drain_stall_novalid", div_stall, 0);
        next();
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs_data = 32'd9; ex_rt_data = 32'd3;
        errs = 0;
        for (int c = 12; c <= 35; c++) begin
            #1;
            if (div_stall !== 1'b1 || hilo_we !== 1'b0 || div_begin !== 1'b0) errs++;
            next();
        end
        #1;
        chk("drain_done_we", hilo_we, 0);
        chk("drain_done_stall", div_stall, 1);
        do_div(0, 32'd9, 32'd3, 32'd0, 32'd3, 32'd9, 32'd3, 0, 0, 0);
        chk("drain_hold", errs, 0);

        // Flush coincident with div_done
        do_div(0, 32'd9, 32'd3, 32'd0, 32'd3, 32'd9, 32'd3, 0, 0, 1);
        next();
        flush = 1'b0;
        #1;
        chk("post_flush_stall", div_stall, 0);
        chk("post_flush_begin", div_begin, 0);

        // Reset in cycle 20 of a divide
        next();
        ex_div_valid = 1'b1; ex_div_signed = 1'b1; ex_rs_data = 32'hffff_fff9; ex_rt_data = 32'd2;
        next();
        ex_div_valid = 1'b0;
        for (int c = 2; c <= 20; c++) next();
        rst = 1'b1;
        next();
        #1;
        chk("mid_rst_begin", div_begin, 0);
        chk("mid_rst_we", hilo_we, 0);
        chk("mid_rst_stall", div_stall, 0);
        chk("mid_rst_ops", div_dividend | div_divisor, 0);
        chk("mid_rst_signs", {div_sign, div_dividend_sign}, 0);
        chk("mid_rst_wdata", hi_wdata | lo_wdata, 0);
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 24; c++) begin
            next(); #1;
            if (hilo_we !== 1'b0 || div_stall !== 1'b0) errs++;
        end
        chk("post_rst_quiet", errs, 0);

        // Back-to-back DIVU 9/3 then 8/2
        do_div(0, 32'd9, 32'd3, 32'd0, 32'd3, 32'd9, 32'd3, 0, 0, 0);
        do_div(0, 32'd8, 32'd2, 32'd0, 32'd4, 32'd8, 32'd2, 0, 0, 0);

        next(); next();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
